flip_flop_d_pipe: RTL

- Parametrised multi-bit D-register pipeline; next generation of the single-bit D flip-flop.
- Delays a WIDTH-bit word by DEPTH clock-enabled stages.
- Carries a per-stage valid bit.
- Adds clock enable, synchronous clear and an occupancy counter.
- Used wherever the design needs aligned, stallable delay of data plus qualifier. DEPTH=1 gives an enhanced D flip-flop.

---
 rtl/flip_flop_d_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/flip_flop_d_pipe.sv
// -----------------------------------------------------------------------------
// flip_flop_d_pipe
//
// Parametrised multi-bit D-register pipeline with a per-stage valid bit.
// A WIDTH-bit word and its qualifier are delayed by DEPTH clock-enabled
// stages. The pipeline can be stalled (en=0) and cleared synchronously
// (clr=1). It keeps a registered count of how many stages hold a valid word.
// With DEPTH=1 it behaves as an enhanced D flip-flop.
//
// Parameters
//   WIDTH   : data word width in bits (>=1)
//   DEPTH   : number of register stages (>=1); latency in enabled cycles
//   RST_VAL : value loaded into every data stage on reset or clear
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-low reset
//   en      in   stage enable: 1 = shift on this edge, 0 = hold all state
//   clr     in   synchronous clear, takes priority over en
//   d       in   data into stage 0
//   d_valid in   qualifier for d
//   q       out  data of the last stage (DEPTH-1)
//   q_valid out  valid bit of the last stage
//   busy    out  1 when any stage holds a valid word
//   count   out  number of stages whose valid bit is set (0..DEPTH)
//
// Flow control: there is no back-pressure handshake. A word is accepted
// into stage 0 on every rising edge where en=1 and clr=0. Whatever was in
// the last stage on that edge leaves the pipe. When en=0, d and d_valid are
// ignored and nothing moves. clr discards the incoming word and every word
// in flight, whatever en is.
//
// Every output comes straight from a flop or from a flop-only expression.
// There is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module flip_flop_d_pipe #(
  parameter int unsigned          WIDTH   = 8,
  parameter int unsigned          DEPTH   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = '0,
  localparam int unsigned         CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic [CW-1:0]    count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Decoded per-edge action. clr wins over en. Reset is handled by the
  // asynchronous branch of the flops.
  logic do_clear;
  logic do_shift;

  assign do_clear = clr;
  assign do_shift = en & ~clr;

  // ---------------------------------------------------------------------------
  // Next-state: data stages
  // Data moves whether or not it is valid, so bubbles carry their data down
  // the pipe unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (do_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RST_VAL;
      end
    end else if (do_shift) begin
      data_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: valid bits
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    if (do_clear) begin
      valid_d = '0;
    end else if (do_shift) begin
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: occupancy counter
  // On a shift, one word enters stage 0 and one word leaves the last stage.
  // Adding the entering valid and subtracting the leaving valid keeps count
  // equal to the number of set valid bits. It therefore stays within
  // 0..DEPTH, and the CW-bit arithmetic never wraps.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count_in;
  logic [CW-1:0] count_out;

  assign count_in  = CW'(d_valid);
  assign count_out = CW'(valid_q[DEPTH-1]);

  always_comb begin
    count_d = count_q;
    if (do_clear) begin
      count_d = '0;
    end else if (do_shift) begin
      count_d = count_q + count_in - count_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all register-derived)
  // ---------------------------------------------------------------------------
  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;
  assign busy    = (count_q != '0);

endmodule
